// File: rtl/fir_log_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fir_log_pkg
// Brief    : Shared state encoding and default widths for the FIR capture path.
// Revision : 1.0 - initial release
// ============================================================================
package fir_log_pkg;

    localparam int c_NB_DATA = 8;
    localparam int c_NB_SEL  = 2;
    localparam int c_NB_ADDR = 10;

    typedef logic [2:0] state_t;

    localparam state_t c_ST_IDLE    = 3'd0;
    localparam state_t c_ST_SETTLE  = 3'd1;
    localparam state_t c_ST_ARMED   = 3'd2;
    localparam state_t c_ST_CAPTURE = 3'd3;
    localparam state_t c_ST_DONE    = 3'd4;

endpackage
`default_nettype wire

// File: rtl/fir_capture_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : fir_capture_ctrl_if
// Brief    : Host/control bundle of the capture sequencer (master = host side).
// Revision : 1.0 - initial release
// ============================================================================
interface fir_capture_ctrl_if #(
    parameter int NB_DATA  = fir_log_pkg::c_NB_DATA,
    parameter int NB_SEL   = fir_log_pkg::c_NB_SEL,
    parameter int NB_ADDR  = fir_log_pkg::c_NB_ADDR,
    parameter int NB_DECIM = 4
);
    logic                 i_start;
    logic                 i_abort;
    logic [NB_SEL-1:0]    i_sel_req;
    logic [NB_DECIM-1:0]  i_decim;
    logic [NB_ADDR-1:0]   i_len;
    logic [NB_DATA-1:0]   i_data;
    logic [NB_ADDR-1:0]   i_rd_addr;
    logic [NB_SEL-1:0]    o_sel;
    logic                 o_enable;
    logic                 o_busy;
    logic                 o_done;
    logic [NB_ADDR:0]     o_count;
    logic [NB_DATA-1:0]   o_rd_data;

    modport master (
        output i_start, i_abort, i_sel_req, i_decim, i_len, i_data, i_rd_addr,
        input  o_sel, o_enable, o_busy, o_done, o_count, o_rd_data
    );

    modport slave (
        input  i_start, i_abort, i_sel_req, i_decim, i_len, i_data, i_rd_addr,
        output o_sel, o_enable, o_busy, o_done, o_count, o_rd_data
    );
endinterface
`default_nettype wire

// File: rtl/log_ram.sv
`default_nettype none
// ============================================================================
// Module   : log_ram
// Brief    : Simple dual-port RAM, one write port, registered read-first read.
// Revision : 1.0 - initial release
// ============================================================================
module log_ram #(
    parameter int NB_DATA = 8,
    parameter int NB_ADDR = 10
) (
    input  wire logic               i_clock,
    input  wire logic               i_reset,
    input  wire logic               i_we,
    input  wire logic [NB_ADDR-1:0] i_waddr,
    input  wire logic [NB_DATA-1:0] i_wdata,
    input  wire logic [NB_ADDR-1:0] i_raddr,
    output logic      [NB_DATA-1:0] o_rdata
);
    logic [NB_DATA-1:0] r_mem [0:(1<<NB_ADDR)-1];
    logic [NB_DATA-1:0] r_rdata;

    // Storage is intentionally not reset; only the read register is.
    always_ff @(posedge i_clock) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;
endmodule
`default_nettype wire

// File: rtl/fir_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fir_capture_ctrl
// Brief    : Drives gen_fir select/enable, flushes, then logs decimated samples.
//            Optional zero-crossing trigger: define FIR_CAPTURE_TRIGGER_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fir_capture_ctrl
    import fir_log_pkg::*;
#(
    parameter int NB_DATA       = c_NB_DATA,
    parameter int NB_SEL        = c_NB_SEL,
    parameter int NB_ADDR       = c_NB_ADDR,
    parameter int NB_DECIM      = 4,
    parameter int SETTLE_CYCLES = 16
) (
    input  wire logic         i_clock,
    input  wire logic         i_reset,
    fir_capture_ctrl_if.slave bus
);
    localparam int                  c_NB_SET   = $clog2(SETTLE_CYCLES) + 1;
    localparam logic [c_NB_SET-1:0] c_SET_LAST = c_NB_SET'(SETTLE_CYCLES - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [NB_SEL-1:0]     r_sel;
    logic [NB_DECIM-1:0]   r_decim;
    logic [NB_DECIM-1:0]   r_dcnt;
    logic [NB_ADDR-1:0]    r_len;
    logic [NB_ADDR-1:0]    r_addr;
    logic [NB_ADDR:0]      r_count;
    logic [c_NB_SET-1:0]   r_settle;
    logic                  r_active;
    logic                  r_done;
    logic                  w_start_ok;
    logic                  w_we;
    logic                  w_last;
    logic                  w_active_nxt;
    logic                  w_done_nxt;

`ifdef FIR_CAPTURE_TRIGGER_EN
    logic [NB_DATA-1:0]    r_prev;
    logic [NB_ADDR-1:0]    r_tcnt;
    logic                  w_cross;

    // Rising zero crossing: previous sample negative, current non-negative.
    assign w_cross = (r_state == c_ST_ARMED) && r_prev[NB_DATA-1] && !bus.i_data[NB_DATA-1];
`endif

    assign w_start_ok = bus.i_start && !bus.i_abort &&
                        ((r_state == c_ST_IDLE) || (r_state == c_ST_DONE));

    always_comb begin
        w_we = (r_state == c_ST_CAPTURE) && (r_dcnt == '0);
`ifdef FIR_CAPTURE_TRIGGER_EN
        w_we = w_we || w_cross;
`endif
        w_last = w_we && (r_addr == r_len);
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state  <= c_ST_IDLE;
            r_active <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_active <= w_active_nxt;
            r_done   <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (bus.i_abort) begin
            w_state_nxt = c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE, c_ST_DONE: begin
                    if (bus.i_start) w_state_nxt = c_ST_SETTLE;
                end
                c_ST_SETTLE: begin
                    if (r_settle == c_SET_LAST) begin
`ifdef FIR_CAPTURE_TRIGGER_EN
                        w_state_nxt = c_ST_ARMED;
`else
                        w_state_nxt = c_ST_CAPTURE;
`endif
                    end
                end
`ifdef FIR_CAPTURE_TRIGGER_EN
                c_ST_ARMED: begin
                    if (w_last)              w_state_nxt = c_ST_DONE;
                    else if (w_cross)        w_state_nxt = c_ST_CAPTURE;
                    else if (r_tcnt == '1)   w_state_nxt = c_ST_DONE;
                end
`endif
                c_ST_CAPTURE: begin
                    if (w_last) w_state_nxt = c_ST_DONE;
                end
                default: w_state_nxt = c_ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_active_nxt = (w_state_nxt == c_ST_SETTLE) || (w_state_nxt == c_ST_ARMED) ||
                       (w_state_nxt == c_ST_CAPTURE);
        w_done_nxt   = (w_state_nxt == c_ST_DONE);
    end

    // Counters hold on abort so the host can still see the partial count.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_sel    <= '0;
            r_decim  <= '0;
            r_len    <= '0;
            r_addr   <= '0;
            r_count  <= '0;
            r_dcnt   <= '0;
            r_settle <= '0;
        end else if (w_start_ok) begin
            r_sel    <= bus.i_sel_req;
            r_decim  <= bus.i_decim;
            r_len    <= bus.i_len;
            r_addr   <= '0;
            r_count  <= '0;
            r_dcnt   <= '0;
            r_settle <= '0;
        end else begin
            if (r_state == c_ST_SETTLE) begin
                r_settle <= r_settle + 1'b1;
            end
            if (w_we) begin
                r_addr  <= r_addr + 1'b1;
                r_count <= r_count + 1'b1;
                r_dcnt  <= r_decim;
            end else if (r_state == c_ST_CAPTURE) begin
                r_dcnt  <= r_dcnt - 1'b1;
            end
        end
    end

`ifdef FIR_CAPTURE_TRIGGER_EN
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_prev <= '0;
            r_tcnt <= '0;
        end else begin
            r_prev <= bus.i_data;
            if (w_start_ok) begin
                r_tcnt <= '0;
            end else if (r_state == c_ST_ARMED) begin
                r_tcnt <= r_tcnt + 1'b1;
            end
        end
    end
`endif

    log_ram #(
        .NB_DATA (NB_DATA),
        .NB_ADDR (NB_ADDR)
    ) u_log_ram (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_we    (w_we),
        .i_waddr (r_addr),
        .i_wdata (bus.i_data),
        .i_raddr (bus.i_rd_addr),
        .o_rdata (bus.o_rd_data)
    );

    assign bus.o_sel    = r_sel;
    assign bus.o_enable = r_active;
    assign bus.o_busy   = r_active;
    assign bus.o_done   = r_done;
    assign bus.o_count  = r_count;
endmodule
`default_nettype wire
